// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - oversampled SPI slave with TX holding register, all CPOL/CPHA modes
module spi_slave_sync #(
    parameter int DATA_BITS   = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_TX_data,
    input  logic                 i_TX_valid,
    output logic                 o_TX_ready,
    output logic [DATA_BITS-1:0] o_RX_data,
    output logic                 o_RX_valid,
    output logic                 o_busy,
    output logic                 o_TX_underrun,
    output logic                 o_frame_err,
    output logic                 o_miso,
    output logic                 o_miso_oe,
    input  logic                 i_ssel_n,
    input  logic                 i_mosi,
    input  logic                 i_sck
);
    localparam int CNT_W   = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ssel_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_ssel_prev;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_busy;
    logic                   r_miso_oe;
    logic                   r_frame_err;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_tx_ready;
    logic                   r_underrun;

    logic                   w_sck;
    logic                   w_ssel;
    logic                   w_mosi;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample_edge;
    logic                   w_shift_edge;
    logic                   w_ssel_fall;
    logic                   w_ssel_rise;
    logic                   w_active_ok;
    logic                   w_load;
    logic                   w_tx_write;
    logic                   w_flushed;
    logic [DATA_BITS-1:0]   w_rx_next;
    logic [DATA_BITS-1:0]   w_tx_shifted;

    assign w_sck         = r_sck_sync[SYNC_STAGES-1];
    assign w_ssel        = r_ssel_sync[SYNC_STAGES-1];
    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead        = (r_sck_prev == CPOL) && (w_sck != CPOL);
    assign w_trail       = (r_sck_prev != CPOL) && (w_sck == CPOL);
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead : w_trail;
    assign w_ssel_fall   = r_ssel_prev && !w_ssel;
    assign w_ssel_rise   = !r_ssel_prev && w_ssel;
    // An SSEL rise wins over any SCK edge seen in the same cycle.
    assign w_active_ok   = (r_state == ACTIVE) && !w_ssel_rise;
    assign w_load        = ((r_state == IDLE) && w_ssel_fall && !CPHA) ||
                           (w_active_ok && w_shift_edge && (r_bit_cnt == '0));
    assign w_tx_write    = i_TX_valid && r_tx_ready;
    // The reset values of the synchroniser must drain out before SSEL is trusted,
    // otherwise a frame already running at reset release would look like a new one.
    assign w_flushed     = (r_flush_cnt == FLUSH_W'(SYNC_STAGES + 1));
    assign w_rx_next     = MSB_FIRST ? {r_rx_shift[DATA_BITS-2:0], w_mosi}
                                     : {w_mosi, r_rx_shift[DATA_BITS-1:1]};
    assign w_tx_shifted  = MSB_FIRST ? {r_tx_shift[DATA_BITS-2:0], FILL_BIT}
                                     : {FILL_BIT, r_tx_shift[DATA_BITS-1:1]};

    assign o_TX_ready    = r_tx_ready;
    assign o_RX_data     = r_rx_data;
    assign o_RX_valid    = r_rx_valid;
    assign o_busy        = r_busy;
    assign o_TX_underrun = r_underrun;
    assign o_frame_err   = r_frame_err;
    assign o_miso_oe     = r_miso_oe;
    assign o_miso        = MSB_FIRST ? r_tx_shift[DATA_BITS-1] : r_tx_shift[0];

    // Bring the asynchronous pins into i_clk and keep one delayed copy for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_sync  <= {SYNC_STAGES{CPOL}};
            r_ssel_sync <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= CPOL;
            r_ssel_prev <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], i_ssel_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_prev  <= w_sck;
            r_ssel_prev <= w_ssel;
        end
    end

    // Frame FSM: framing, receive shifting, bit counting and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= WAIT_HIGH;
            r_flush_cnt <= '0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                WAIT_HIGH: begin
                    if (!w_flushed) begin
                        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
                    end else if (w_ssel) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_ssel_fall) begin
                        r_state   <= ACTIVE;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_miso_oe <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_ssel_rise) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sample_edge) begin
                        r_rx_shift <= w_rx_next;
                        if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            r_bit_cnt  <= '0;
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= WAIT_HIGH;
            endcase
        end
    end

    // Transmit path: holding register handshake, word loads and MISO shifting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_shift <= {DATA_BITS{FILL_BIT}};
            r_hold     <= '0;
            r_tx_ready <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                if (!r_tx_ready) begin
                    r_tx_shift <= r_hold;
                end else begin
                    r_tx_shift <= {DATA_BITS{FILL_BIT}};
                    r_underrun <= 1'b1;
                end
            end else if (w_active_ok && w_shift_edge) begin
                r_tx_shift <= w_tx_shifted;
            end
            if (w_tx_write) begin
                r_hold     <= i_TX_data;
                r_tx_ready <= 1'b0;
            end else if (w_load && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - self-checking bench for spi_slave_sync over all modes and bit orders
module tb_spi_slave_sync;
    localparam int H = 6;

    typedef struct {
        int              m;
        bit              do_reset;
        int              nbits;
        int              ntx;
        logic [15:0]     tx0;
        logic [15:0]     tx1;
        logic [2:0][15:0] rxw;
        logic [2:0][15:0] em;
        int              e_ur;
        int              e_rxv;
        int              e_ferr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        sck;
    logic [7:0]        ssel_n;
    logic [7:0]        mosi;
    logic [7:0]        tx_valid;
    logic [15:0]       tx_data [8];
    logic [7:0]        tx_ready, rx_valid, busy, underrun, ferr, miso, miso_oe;
    logic [7:0][15:0]  rx_data;

    int n_pass = 0;
    int n_total = 0;
    int n_ur, n_ferr, n_busy;
    logic [15:0] feed[$];
    logic [15:0] rx_got[$];
    bit          mosi_bits[$];
    bit          miso_bits[$];
    vec_t        vt[8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        localparam bit LP_CPOL = (g % 2) == 1;
        localparam bit LP_CPHA = ((g / 2) % 2) == 1;
        localparam bit LP_MSB  = ((g / 4) % 2) == 1;
        spi_slave_sync #(
            .DATA_BITS(16), .CPOL(LP_CPOL), .CPHA(LP_CPHA), .MSB_FIRST(LP_MSB),
            .SYNC_STAGES(2), .FILL_BIT(1'b1)
        ) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_TX_data(tx_data[g]), .i_TX_valid(tx_valid[g]), .o_TX_ready(tx_ready[g]),
            .o_RX_data(rx_data[g]), .o_RX_valid(rx_valid[g]), .o_busy(busy[g]),
            .o_TX_underrun(underrun[g]), .o_frame_err(ferr[g]),
            .o_miso(miso[g]), .o_miso_oe(miso_oe[g]),
            .i_ssel_n(ssel_n[g]), .i_mosi(mosi[g]), .i_sck(sck[g])
        );
    end

    function automatic bit f_cpha(input int m);
        return ((m / 2) % 2) == 1;
    endfunction

    function automatic bit f_msb(input int m);
        return ((m / 4) % 2) == 1;
    endfunction

    function automatic vec_t mk(input int m, input bit rs, input int nb, input int ntx,
                                input logic [15:0] t0, input logic [15:0] t1,
                                input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                                input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                                input int ur, input int rxv, input int fe);
        vec_t v;
        v.m = m; v.do_reset = rs; v.nbits = nb; v.ntx = ntx; v.tx0 = t0; v.tx1 = t1;
        v.rxw[0] = r0; v.rxw[1] = r1; v.rxw[2] = r2;
        v.em[0] = e0; v.em[1] = e1; v.em[2] = e2;
        v.e_ur = ur; v.e_rxv = rxv; v.e_ferr = fe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One i_clk cycle on instance m: handshake bookkeeping plus output event capture.
    task automatic step(input int m);
        bit acc;
        logic [15:0] dummy;
        acc = tx_valid[m] && tx_ready[m];
        @(posedge clk);
        #1;
        if (acc && feed.size() > 0) dummy = feed.pop_front();
        tx_valid[m] = feed.size() > 0;
        if (feed.size() > 0) tx_data[m] = feed[0];
        if (rx_valid[m]) rx_got.push_back(rx_data[m]);
        if (underrun[m]) n_ur++;
        if (ferr[m]) n_ferr++;
        if (busy[m]) n_busy++;
    endtask

    task automatic wait_n(input int m, input int n);
        repeat (n) step(m);
    endtask

    task automatic clear_counts();
        n_ur = 0; n_ferr = 0; n_busy = 0;
        rx_got.delete();
        miso_bits.delete();
    endtask

    task automatic do_reset();
        feed.delete();
        tx_valid = '0;
        rst = 1'b1;
        wait_n(0, 2);
        rst = 1'b0;
        wait_n(0, 6);
        clear_counts();
    endtask

    task automatic build_mosi(input int m, input int nbits, input logic [2:0][15:0] w);
        mosi_bits.delete();
        for (int i = 0; i < nbits; i++)
            mosi_bits.push_back(f_msb(m) ? w[i / 16][15 - (i % 16)] : w[i / 16][i % 16]);
    endtask

    function automatic logic [15:0] miso_word(input int m, input int k);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) begin
            if (f_msb(m)) w[15 - i] = miso_bits[k * 16 + i];
            else          w[i]      = miso_bits[k * 16 + i];
        end
        return w;
    endfunction

    // Acts as the SPI master: optional SSEL fall, nbits clocks, optional SSEL rise.
    task automatic run_bits(input int m, input bit start, input int nbits, input bit finish);
        bit cpol, cpha;
        cpol = (m % 2) == 1;
        cpha = f_cpha(m);
        if (start) begin
            ssel_n[m] = 1'b0;
            wait_n(m, H);
            check($sformatf("m%0d_busy_start", m), busy[m], 1);
            check($sformatf("m%0d_oe_start", m), miso_oe[m], 1);
        end
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = mosi_bits[i];
                wait_n(m, H);
                miso_bits.push_back(miso[m]);
                sck[m] = ~cpol;
                wait_n(m, H);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi[m] = mosi_bits[i];
                wait_n(m, H);
                miso_bits.push_back(miso[m]);
                sck[m] = cpol;
                wait_n(m, H);
            end
        end
        wait_n(m, H);
        if (finish) begin
            ssel_n[m] = 1'b1;
            wait_n(m, H);
        end
    endtask

    task automatic prep(input int m);
        tx_valid[m] = feed.size() > 0;
        if (feed.size() > 0) tx_data[m] = feed[0];
        wait_n(m, 4);
    endtask

    initial begin
        int m, nw, loads, exp_ur;
        logic [15:0] pool[$];
        logic [15:0] exp_tx[$];
        logic [2:0][15:0] rw;

        for (int i = 0; i < 8; i++) begin
            sck[i] = (i % 2) == 1;
            tx_data[i] = 16'h0;
        end
        ssel_n = '1; mosi = '0; tx_valid = '0;

        vt[0] = mk(4, 1, 16, 2, 16'hA5C3, 16'h5A5A, 16'h1234, 0, 0, 16'hA5C3, 0, 0, 0, 1, 0);
        vt[1] = mk(0, 1, 16, 1, 16'h0001, 0, 16'h8000, 0, 0, 16'h0001, 0, 0, 1, 1, 0);
        vt[2] = mk(1, 1, 16, 1, 16'h0001, 0, 16'h8000, 0, 0, 16'h0001, 0, 0, 1, 1, 0);
        vt[3] = mk(2, 1, 16, 1, 16'h0001, 0, 16'h8000, 0, 0, 16'h0001, 0, 0, 0, 1, 0);
        vt[4] = mk(3, 1, 16, 1, 16'h0001, 0, 16'h8000, 0, 0, 16'h0001, 0, 0, 0, 1, 0);
        vt[5] = mk(6, 1, 48, 2, 16'h1111, 16'h2222, 16'hBEEF, 16'h0F0F, 16'h8001,
                   16'h1111, 16'h2222, 16'hFFFF, 1, 3, 0);
        vt[6] = mk(4, 1, 5, 1, 16'h1357, 0, 16'hF800, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[7] = mk(4, 0, 16, 1, 16'h3C3C, 0, 16'h6E6E, 0, 0, 16'h3C3C, 0, 0, 1, 1, 0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rst%0d_ready", i), tx_ready[i], 1);
            check($sformatf("rst%0d_rxdata", i), rx_data[i], 0);
            check($sformatf("rst%0d_flags", i), {rx_valid[i], busy[i], underrun[i], ferr[i], miso_oe[i]}, 0);
            check($sformatf("rst%0d_miso", i), miso[i], 1);
        end

        for (int e = 0; e < 8; e++) begin
            m = vt[e].m;
            if (vt[e].do_reset) do_reset();
            else clear_counts();
            feed.delete();
            feed.push_back(vt[e].tx0);
            if (vt[e].ntx > 1) feed.push_back(vt[e].tx1);
            prep(m);
            build_mosi(m, vt[e].nbits, vt[e].rxw);
            run_bits(m, 1, vt[e].nbits, 1);
            for (int k = 0; k < vt[e].nbits / 16; k++)
                check($sformatf("v%0d_miso%0d", e, k), miso_word(m, k), vt[e].em[k]);
            check($sformatf("v%0d_rxv", e), rx_got.size(), vt[e].e_rxv);
            for (int k = 0; k < rx_got.size() && k < 3; k++)
                check($sformatf("v%0d_rx%0d", e, k), rx_got[k], vt[e].rxw[k]);
            check($sformatf("v%0d_underrun", e), n_ur, vt[e].e_ur);
            check($sformatf("v%0d_frame_err", e), n_ferr, vt[e].e_ferr);
            check($sformatf("v%0d_end_busy_oe", e), {busy[m], miso_oe[m]}, 0);
        end

        // Reset in the middle of a frame while SSEL stays low.
        m = 4;
        do_reset();
        rw = {16'h0, 16'h0, 16'hFFFF};
        build_mosi(m, 16, rw);
        run_bits(m, 1, 5, 0);
        rst = 1'b1;
        step(m);
        check("mid_rst_ready", tx_ready[m], 1);
        check("mid_rst_rxdata", rx_data[m], 0);
        check("mid_rst_flags", {rx_valid[m], busy[m], underrun[m], ferr[m], miso_oe[m]}, 0);
        check("mid_rst_miso", miso[m], 1);
        rst = 1'b0;
        clear_counts();
        run_bits(m, 0, 16, 1);
        check("mid_rst_busy_cycles", n_busy, 0);
        check("mid_rst_rx_count", rx_got.size(), 0);
        check("mid_rst_underrun", n_ur, 0);
        clear_counts();
        feed.push_back(16'hC0DE);
        prep(m);
        rw = {16'h0, 16'h0, 16'h4242};
        build_mosi(m, 16, rw);
        run_bits(m, 1, 16, 1);
        check("post_rst_miso", miso_word(m, 0), 16'hC0DE);
        check("post_rst_rx_count", rx_got.size(), 1);
        if (rx_got.size() > 0) check("post_rst_rx", rx_got[0], 16'h4242);
        check("post_rst_frame_err", n_ferr, 0);

        // Random frames with i_TX_valid held high and fresh data on every accept.
        for (int r = 0; r < 8; r++) begin
            m = r;
            do_reset();
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw + 2; k++) feed.push_back(16'($urandom));
            for (int k = 0; k < 3; k++) rw[k] = 16'($urandom);
            pool = feed;
            exp_tx.delete();
            exp_ur = 0;
            loads = f_cpha(m) ? nw : nw + 1;
            for (int k = 0; k < loads; k++) begin
                if (pool.size() > 0) exp_tx.push_back(pool.pop_front());
                else begin exp_tx.push_back(16'hFFFF); exp_ur++; end
            end
            prep(m);
            build_mosi(m, nw * 16, rw);
            run_bits(m, 1, nw * 16, 1);
            for (int k = 0; k < nw; k++)
                check($sformatf("rnd%0d_miso%0d", r, k), miso_word(m, k), exp_tx[k]);
            check($sformatf("rnd%0d_rxv", r), rx_got.size(), nw);
            for (int k = 0; k < rx_got.size() && k < nw; k++)
                check($sformatf("rnd%0d_rx%0d", r, k), rx_got[k], rw[k]);
            check($sformatf("rnd%0d_underrun", r), n_ur, exp_ur);
            check($sformatf("rnd%0d_frame_err", r), n_ferr, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
